// File: rtl/uart_rx_if.sv
// Receive-side signal bundle between the serial pin and the byte consumer.
interface uart_rx_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    // Receiver side: consumes the serial line, produces the byte and status.
    modport master (
        input  data_in,
        output data_out,
        output rx_done,
        output rx_busy,
        output frame_err
    );

    // Line driver / byte consumer side.
    modport slave (
        output data_in,
        input  data_out,
        input  rx_done,
        input  rx_busy,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line.
// The line is oversampled 16x per bit, and every bit is sampled at mid-bit.
// A low stop bit raises frame_err. The receiver then waits for the line to go
// high again before it will accept another start bit.
module uart_rx #(
    parameter int unsigned CLK_FRQ    = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      areset,
    uart_rx_if.master bus
);

    localparam int unsigned OS_DIV = CLK_FRQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int unsigned S_W    = 4;
    localparam int unsigned B_W    = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);
    localparam logic [S_W-1:0]   S_MID    = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q;
    logic                rx_s_q;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [S_W-1:0]      s_cnt_q, s_cnt_d;
    logic [B_W-1:0]      b_cnt_q, b_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                rx_done_q, rx_done_d;
    logic                rx_busy_q, rx_busy_d;
    logic                frame_err_q, frame_err_d;
    logic                tick_c;

    // Oversample tick: one clk per wrap of the free-running divider.
    assign tick_c = (div_q == DIV_LAST);

    // Next-state logic for the divider, the framing FSM and the registered outputs.
    always_comb begin
        div_d       = tick_c ? '0 : div_q + DIV_W'(1);
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        b_cnt_d     = b_cnt_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_busy_d   = rx_busy_q;

        case (state_q)
            IDLE: begin
                rx_busy_d = 1'b0;
                if (tick_c && !rx_s_q) begin
                    state_d   = START;
                    s_cnt_d   = '0;
                    rx_busy_d = 1'b1;
                end
            end
            START: begin
                if (tick_c) begin
                    if (s_cnt_q == S_MID) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            b_cnt_d = '0;
                        end else begin
                            // Line went back high before mid start bit: treat it as a glitch.
                            state_d   = IDLE;
                            rx_busy_d = 1'b0;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick_c) begin
                    s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + S_W'(1);
                    if (s_cnt_q == S_LAST) begin
                        shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
                        if (b_cnt_q == B_LAST) begin
                            state_d = STOP;
                        end else begin
                            b_cnt_d = b_cnt_q + B_W'(1);
                        end
                    end
                end
            end
            STOP: begin
                if (tick_c) begin
                    s_cnt_d = (s_cnt_q == S_LAST) ? '0 : s_cnt_q + S_W'(1);
                    if (s_cnt_q == S_LAST) begin
                        if (rx_s_q) begin
                            data_out_d = shift_q;
                            rx_done_d  = 1'b1;
                            rx_busy_d  = 1'b0;
                            state_d    = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK_WAIT;
                        end
                    end
                end
            end
            BREAK_WAIT: begin
                // A held-low line must not be taken as a new start bit.
                if (tick_c && rx_s_q) begin
                    state_d   = IDLE;
                    rx_busy_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                s_cnt_d   = '0;
                b_cnt_d   = '0;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            div_q       <= '0;
            s_cnt_q     <= '0;
            b_cnt_q     <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            rx_done_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= bus.data_in;
            rx_s_q      <= sync1_q;
            div_q       <= div_d;
            s_cnt_q     <= s_cnt_d;
            b_cnt_q     <= b_cnt_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            rx_done_q   <= rx_done_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.rx_busy   = rx_busy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-written corner sequences and random frames.
// Observed pulses are gathered as an event list and compared with the list the frames should produce.
module tb_uart_rx;

    localparam int unsigned CLK_NS  = 10;
    localparam int unsigned BIT_CLK = 432;

    logic clk;
    logic areset;

    uart_rx_if bus ();

    uart_rx u_dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per received frame: {frame_err, byte}; 9'h100 marks a framing error.
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         viol   = 0;
    bit         saw_busy = 1'b0;

    // Collect output pulses; flag illegal output combinations.
    always @(negedge clk) begin
        if (bus.rx_done) got_q.push_back({1'b0, bus.data_out});
        if (bus.frame_err) got_q.push_back(9'h100);
        if (bus.rx_done && bus.frame_err) viol++;
        if (bus.rx_done && bus.rx_busy) viol++;
        if (bus.rx_busy) saw_busy = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_events(input string name);
        chk({name, " event count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, " event"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // Drive one 8N1 frame; a low stop bit is followed by hold_bits extra low bit times.
    task automatic send_frame(input logic [7:0] b, input int unsigned bclk, input bit stop,
                              input int unsigned hold_bits, input int unsigned gap_clk);
        bus.data_in = 1'b0;
        #(bclk * CLK_NS);
        for (int i = 0; i < 8; i++) begin
            bus.data_in = b[i];
            #(bclk * CLK_NS);
        end
        bus.data_in = stop;
        #(bclk * CLK_NS);
        if (!stop) #(hold_bits * bclk * CLK_NS);
        bus.data_in = 1'b1;
        #(gap_clk * CLK_NS);
    endtask

    typedef struct {
        logic [7:0]  data;
        int unsigned bclk;
        bit          stop;
        int unsigned hold;
        bit          exp_done;
        bit          exp_ferr;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t        vecs[6];
    logic [7:0]  model_out;
    logic [7:0]  rb;
    int unsigned rbclk;
    bit          rstop;
    int unsigned rhold;
    int unsigned rgap;

    initial begin
        vecs[0] = '{8'hA5, 432, 1'b1, 0, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h11, 432, 1'b1, 0, 1'b1, 1'b0, 8'h11};
        vecs[2] = '{8'h3C, 432, 1'b0, 3, 1'b0, 1'b1, 8'h11};
        vecs[3] = '{8'h7E, 432, 1'b1, 0, 1'b1, 1'b0, 8'h7E};
        vecs[4] = '{8'h5A, 448, 1'b1, 0, 1'b1, 1'b0, 8'h5A};
        vecs[5] = '{8'h5A, 416, 1'b1, 0, 1'b1, 1'b0, 8'h5A};

        // Reset values.
        areset      = 1'b1;
        bus.data_in = 1'b1;
        #23;
        chk("reset data_out", 32'(bus.data_out), 32'h00);
        chk("reset rx_done", 32'(bus.rx_done), 32'h0);
        chk("reset rx_busy", 32'(bus.rx_busy), 32'h0);
        chk("reset frame_err", 32'(bus.frame_err), 32'h0);
        repeat (3) @(negedge clk);
        areset = 1'b0;
        #(BIT_CLK * CLK_NS);
        got_q.delete();

        // Directed frame table.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].exp_done) exp_q.push_back({1'b0, vecs[v].exp_out});
            if (vecs[v].exp_ferr) exp_q.push_back(9'h100);
            send_frame(vecs[v].data, vecs[v].bclk, vecs[v].stop, vecs[v].hold, BIT_CLK);
            check_events($sformatf("vec%0d", v));
            chk($sformatf("vec%0d data_out", v), 32'(bus.data_out), 32'(vecs[v].exp_out));
            chk($sformatf("vec%0d rx_busy idle", v), 32'(bus.rx_busy), 32'h0);
        end

        // Short low glitch from idle: busy briefly, then idle with no pulse.
        saw_busy    = 1'b0;
        bus.data_in = 1'b0;
        #(108 * CLK_NS);
        bus.data_in = 1'b1;
        #(BIT_CLK * CLK_NS);
        chk("glitch saw busy", 32'(saw_busy), 32'h1);
        chk("glitch busy dropped", 32'(bus.rx_busy), 32'h0);
        check_events("glitch");
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, BIT_CLK, 1'b1, 0, BIT_CLK);
        check_events("after glitch");
        chk("after glitch data_out", 32'(bus.data_out), 32'h3C);

        // Back-to-back frames with no idle gap.
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        send_frame(8'h00, BIT_CLK, 1'b1, 0, 0);
        send_frame(8'hFF, BIT_CLK, 1'b1, 0, BIT_CLK);
        check_events("back-to-back");
        chk("back-to-back data_out", 32'(bus.data_out), 32'hFF);

        // Reset in the middle of bit 4 of 0xC3.
        rb          = 8'hC3;
        bus.data_in = 1'b0;
        #(BIT_CLK * CLK_NS);
        for (int i = 0; i < 4; i++) begin
            bus.data_in = rb[i];
            #(BIT_CLK * CLK_NS);
        end
        bus.data_in = rb[4];
        #(BIT_CLK * CLK_NS / 2);
        chk("busy before reset", 32'(bus.rx_busy), 32'h1);
        areset = 1'b1;
        #1;
        chk("midreset data_out", 32'(bus.data_out), 32'h00);
        chk("midreset rx_busy", 32'(bus.rx_busy), 32'h0);
        chk("midreset rx_done", 32'(bus.rx_done), 32'h0);
        chk("midreset frame_err", 32'(bus.frame_err), 32'h0);
        bus.data_in = 1'b1;
        #(20 * CLK_NS);
        areset = 1'b0;
        #(BIT_CLK * CLK_NS);
        check_events("aborted frame");
        exp_q.push_back({1'b0, 8'h96});
        send_frame(8'h96, BIT_CLK, 1'b1, 0, BIT_CLK);
        check_events("after reset");
        chk("after reset data_out", 32'(bus.data_out), 32'h96);

        // Random frames against the event-list model.
        model_out = 8'h96;
        for (int n = 0; n < 4; n++) begin
            rb    = 8'($urandom);
            rbclk = $urandom_range(416, 448);
            rstop = ($urandom_range(0, 3) != 0);
            rhold = rstop ? 0 : $urandom_range(0, 2);
            rgap  = rstop ? $urandom_range(0, 200) : $urandom_range(100, 300);
            if (rstop) begin
                exp_q.push_back({1'b0, rb});
                model_out = rb;
            end else begin
                exp_q.push_back(9'h100);
            end
            send_frame(rb, rbclk, rstop, rhold, rgap);
        end
        #(BIT_CLK * CLK_NS);
        check_events("random");
        chk("random data_out", 32'(bus.data_out), 32'(model_out));
        chk("random rx_busy idle", 32'(bus.rx_busy), 32'h0);

        chk("protocol violations", 32'(viol), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
